// File: rtl/multu_hilo.sv
// Iterative shift-add unsigned multiplier with HI/LO result register.
// Takes WIDTH cycles per product; MFHI/MFLO read the result combinationally.
module multu_hilo #(
    parameter int         WIDTH = 32,
    parameter logic [5:0] MULTU = 6'b011001,
    parameter logic [5:0] MFHI  = 6'b010000,
    parameter logic [5:0] MFLO  = 6'b010010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      count;

    // One shift-add step; the upper sum keeps its carry so nothing overflows
    always_comb begin
        if (prod[0]) begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        end
        prod_next = {sum, prod[WIDTH-1:1]};
    end

    // Sequencer: accept MULTU in IDLE, iterate WIDTH times, publish HI/LO once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && signal == MULTU) begin
                        mcand <= dataA;
                        prod  <= {{WIDTH{1'b0}}, dataB};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    prod  <= prod_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        hi    <= prod_next[2*WIDTH-1:WIDTH];
                        lo    <= prod_next[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result readback onto the datapath
    always_comb begin
        dataOut = '0;
        if (signal == MFHI) begin
            dataOut = hi;
        end else if (signal == MFLO) begin
            dataOut = lo;
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Directed and random checks of multu_hilo against an arithmetic model.
// Expected HI/LO come from a plain 64-bit product kept in the bench.
module tb_multu_hilo;

    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_ADD   = 6'b100000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    multu_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .signal  (signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(input string tag);
        logic [5:0] saved;
        saved  = signal;
        signal = OP_MFHI;
        #1 chk({tag, ".hi"}, 64'(dataOut), 64'(exp_hi));
        signal = OP_MFLO;
        #1 chk({tag, ".lo"}, 64'(dataOut), 64'(exp_lo));
        signal = 6'd0;
        #1 chk({tag, ".none"}, 64'(dataOut), 64'd0);
        signal = saved;
    endtask

    // Drive a MULTU request, return at the falling edge after it was taken
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        signal = OP_MULTU;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        signal = 6'd0;
        dataA  = $urandom;
        dataB  = $urandom;
    endtask

    // Wait (bounded) for done; spent = RUN cycles already waited by caller
    task automatic finish_op(input string tag, input int spent,
                             input logic [31:0] a, input logic [31:0] b);
        int cycles;
        int idle_seen;
        logic [63:0] p;
        cycles    = spent;
        idle_seen = 0;
        while (!done && cycles < 40) begin
            if (!busy) idle_seen++;
            cycles++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 64'(cycles), 64'd32);
        chk({tag, ".busy_run"}, 64'(idle_seen), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".busy_end"}, 64'(busy), 64'd0);
        p      = 64'(a) * 64'(b);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        read_hilo(tag);
        @(negedge clk);
        chk({tag, ".done_drop"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] old_lo;
        reset  = 1'b0;
        start  = 1'b0;
        signal = 6'd0;
        dataA  = '0;
        dataB  = '0;
        exp_hi = '0;
        exp_lo = '0;

        // Reset held two cycles
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        read_hilo("rst");
        reset = 1'b1;
        @(negedge clk);

        // 3 * 5
        launch(32'd3, 32'd5);
        finish_op("m3x5", 0, 32'd3, 32'd5);
        chk("m3x5.lo15", 64'(exp_lo), 64'd15);

        // Max operands
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("max", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Shift path and zero operand
        launch(32'h8000_0000, 32'd2);
        finish_op("shift", 0, 32'h8000_0000, 32'd2);
        launch(32'd0, 32'h1234_5678);
        finish_op("zero", 0, 32'd0, 32'h1234_5678);

        // Non-MULTU start in IDLE is ignored
        launch(32'd9, 32'd9);
        finish_op("pre", 0, 32'd9, 32'd9);
        signal = OP_ADD;
        dataA  = 32'd100;
        dataB  = 32'd100;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        chk("add.busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("add.idle", 64'({busy, done}), 64'd0);
        read_hilo("add");

        // Restart in RUN ignored; stale LO readable mid-run
        old_lo = exp_lo;
        a = $urandom;
        b = $urandom;
        launch(a, b);
        repeat (4) @(negedge clk);
        signal = OP_MULTU;
        dataA  = 32'hDEAD_BEEF;
        dataB  = 32'h0BAD_F00D;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        signal = 6'd0;
        repeat (5) @(negedge clk);
        chk("mid.busy", 64'(busy), 64'd1);
        signal = OP_MFLO;
        #1 chk("mid.stale_lo", 64'(dataOut), 64'(old_lo));
        signal = 6'd0;
        finish_op("restart", 10, a, b);

        // Reset at RUN cycle 10
        launch(32'h0001_0001, 32'hFFFF);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        read_hilo("abort");
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) chk("abort.no_done", 64'(done), 64'd0);
        end
        read_hilo("abort2");
        launch(32'd7, 32'd6);
        finish_op("m7x6", 0, 32'd7, 32'd6);
        chk("m7x6.lo42", 64'(exp_lo), 64'd42);

        // Random operands
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 2) a = 32'h0000_0001;
            if (i == 3) b = 32'hFFFF_FFFF;
            launch(a, b);
            finish_op($sformatf("rnd%0d", i), 0, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
